byte_data_memory: RTL and testbench

- Next-generation data RAM for the single-cycle MIPS core, replacing the word-only data memory.
- Byte-addressed; supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Reset clears the array with a one-word-per-cycle clear sequencer instead of a single-cycle bulk clear.
- Flags misaligned and out-of-range accesses, and holds the first faulting address in a sticky capture register.
- Asynchronous read and synchronous write are kept so the single-cycle datapath timing is unchanged.

---
 rtl/byte_data_memory.sv | 177 +++++++++++++++++
 tb/tb_byte_data_memory.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressed data RAM for the single-cycle MIPS core.
// Byte/half/word loads and stores with sign/zero extension on loads,
// asynchronous read, synchronous write, a one-word-per-cycle clear sequence
// after reset, and sticky capture of the first faulting address.
module byte_data_memory #(
    parameter int MEM_DEPTH      = 256,
    parameter int ADDRESS_WIDTH  = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     Req,
    input  logic                     WEN,
    input  logic [1:0]               Size,
    input  logic                     LoadUnsigned,
    input  logic [ADDRESS_WIDTH-1:0] DataAddress,
    input  logic [31:0]              WD,
    output logic [31:0]              RD,
    output logic                     Ready,
    output logic                     Busy,
    output logic                     AccessErr,
    output logic                     ErrSticky,
    output logic [ADDRESS_WIDTH-1:0] ErrAddr,
    output logic [15:0]              testValue
);

    localparam int CNT_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int IDX_W = ADDRESS_WIDTH - 2;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MEM_DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      mem [MEM_DEPTH];

    logic [IDX_W-1:0] word_idx;
    logic [CNT_W-1:0] mem_idx;
    logic [1:0]       lane;
    logic             idle;
    logic             clearing;
    logic             out_of_range;
    logic             misaligned;
    logic             store_en;
    logic [31:0]      rd_word;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [3:0]       lane_en;
    logic [31:0]      store_data;

    // Address decode: word index, byte lane and range check.
    assign word_idx     = DataAddress[ADDRESS_WIDTH-1:2];
    assign mem_idx      = word_idx[CNT_W-1:0];
    assign lane         = DataAddress[1:0];
    assign out_of_range = (word_idx >= DEPTH_IDX);

    // Accesses are only honoured in IDLE and never while reset is held.
    assign idle     = (state == S_IDLE) && !rst;
    assign clearing = (state == S_CLEAR) && !rst;

    // Alignment rules per access size; the reserved size always faults.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        misaligned = 1'b0;
        case (Size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = DataAddress[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign AccessErr = idle && Req && (misaligned || out_of_range);
    assign store_en  = idle && Req && WEN && !misaligned && !out_of_range;

    // Asynchronous read of the indexed word and its byte/half lanes.
    assign rd_word  = out_of_range ? 32'h0 : mem[mem_idx];
    assign sel_byte = rd_word[{lane, 3'b000} +: 8];
    assign sel_half = rd_word[{DataAddress[1], 4'b0000} +: 16];

    // Load data: word-mode view when idle without a request, lane extract otherwise.
    always_comb begin
        RD = 32'h0;
        if (idle) begin
            if (!Req) begin
                RD = rd_word;
            end else if (!(misaligned || out_of_range)) begin
                case (Size)
                    2'b00:   RD = LoadUnsigned ? {24'h0, sel_byte}
                                               : {{24{sel_byte[7]}}, sel_byte};
                    2'b01:   RD = LoadUnsigned ? {16'h0, sel_half}
                                               : {{16{sel_half[15]}}, sel_half};
                    default: RD = rd_word;
                endcase
            end
        end
    end

    // Store lane enables and lane-replicated store data.
    always_comb begin
        lane_en    = 4'b0000;
        store_data = WD;
        case (Size)
            2'b00: begin
                lane_en    = 4'b0001 << lane;
                store_data = {4{WD[7:0]}};
            end
            2'b01: begin
                lane_en    = DataAddress[1] ? 4'b1100 : 4'b0011;
                store_data = {2{WD[15:0]}};
            end
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    // State and clear-counter register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: walk the array once in CLEAR, then sit in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == S_CLEAR) begin
            cnt_next = cnt + 1'b1;
            if (cnt == LAST_CNT) begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        end
    end

    // Array writes: one cleared word per edge in CLEAR, byte-lane stores in IDLE.
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset branch; the clear sequencer zeroes it so it maps onto plain RAM.
        if (clearing) begin
            mem[cnt] <= 32'h0;
        end else if (store_en) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[mem_idx][8*k +: 8] <= store_data[8*k +: 8];
                end
            end
        end
    end

    // Sticky capture of the first faulting address.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ErrSticky <= 1'b0;
            ErrAddr   <= '0;
        end else if (AccessErr && !ErrSticky) begin
            ErrSticky <= 1'b1;
            ErrAddr   <= DataAddress;
        end
    end

    assign Ready     = idle;
    assign Busy      = (state == S_CLEAR);
    assign testValue = mem[0][15:0];

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: behavioural model of the RAM,
// clear timing and error capture, compared against the DUT every cycle,
// plus directed literal expectations and randomized traffic.
module tb_byte_data_memory;

    localparam int DEPTH = 256;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        Req = 1'b0;
    logic        WEN = 1'b0;
    logic [1:0]  Size = 2'b10;
    logic        LoadUnsigned = 1'b0;
    logic [31:0] DataAddress = 32'h0;
    logic [31:0] WD = 32'h0;
    logic [31:0] RD;
    logic        Ready;
    logic        Busy;
    logic        AccessErr;
    logic        ErrSticky;
    logic [31:0] ErrAddr;
    logic [15:0] testValue;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state.
    logic [31:0] m_mem [DEPTH];
    int          m_left = DEPTH;
    bit          m_sticky = 1'b0;
    logic [31:0] m_addr = 32'h0;

    byte_data_memory dut (
        .CLK          (CLK),
        .rst          (rst),
        .Req          (Req),
        .WEN          (WEN),
        .Size         (Size),
        .LoadUnsigned (LoadUnsigned),
        .DataAddress  (DataAddress),
        .WD           (WD),
        .RD           (RD),
        .Ready        (Ready),
        .Busy         (Busy),
        .AccessErr    (AccessErr),
        .ErrSticky    (ErrSticky),
        .ErrAddr      (ErrAddr),
        .testValue    (testValue)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_err(input logic [1:0] sz, input logic [31:0] a);
        bit oor;
        bit mis;
        oor = (a / 4) >= DEPTH;
        mis = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
        return oor || mis;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int idx;
        if ((a / 4) >= DEPTH) return 32'h0;
        idx = int'(a / 4);
        return m_mem[idx];
    endfunction

    // Load value from shift/mask arithmetic and numeric sign extension.
    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        int          sh;
        w  = model_word(a);
        sh = int'(a % 4) * 8;
        if (sz == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Model update on each edge: reset, clear countdown, or access.
    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            m_left   = DEPTH;
            m_sticky = 1'b0;
            m_addr   = 32'h0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else if (Req) begin
            if (addr_err(Size, DataAddress)) begin
                if (!m_sticky) begin
                    m_sticky = 1'b1;
                    m_addr   = DataAddress;
                end
            end else if (WEN) begin
                logic [31:0] mask;
                logic [31:0] val;
                int          sh;
                int          idx;
                sh  = int'(DataAddress % 4) * 8;
                idx = int'(DataAddress / 4);
                if (Size == 2'd0) begin
                    mask = 32'hFF << sh;
                    val  = (WD & 32'hFF) << sh;
                end else if (Size == 2'd1) begin
                    mask = 32'hFFFF << sh;
                    val  = (WD & 32'hFFFF) << sh;
                end else begin
                    mask = 32'hFFFF_FFFF;
                    val  = WD;
                end
                m_mem[idx] = (m_mem[idx] & ~mask) | (val & mask);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            bit          m_idle;
            bit          err;
            bit          chk_rd;
            logic [31:0] e_rd;
            m_idle = !rst && (m_left == 0);
            err    = addr_err(Size, DataAddress);
            chk_rd = 1'b1;
            e_rd   = 32'h0;
            if (m_idle) begin
                if (!Req)           e_rd = model_word(DataAddress);
                else if (err)       e_rd = 32'h0;
                else if (!WEN)      e_rd = model_load(Size, LoadUnsigned, DataAddress);
                else if (Size == 2'd2) e_rd = model_word(DataAddress);
                else                chk_rd = 1'b0;
            end
            if (chk_rd) check("cyc_rd", RD, e_rd);
            check("cyc_ready", {31'h0, Ready}, {31'h0, m_idle});
            check("cyc_busy", {31'h0, Busy}, {31'h0, (rst || m_left > 0)});
            check("cyc_access_err", {31'h0, AccessErr}, {31'h0, (m_idle && Req && err)});
            check("cyc_err_sticky", {31'h0, ErrSticky}, {31'h0, m_sticky});
            check("cyc_err_addr", ErrAddr, m_addr);
            if (!rst && m_left < DEPTH)
                check("cyc_test_value", {16'h0, testValue}, {16'h0, m_mem[0][15:0]});
        end
    end

    task automatic drive(input logic req, input logic wen, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge CLK);
        #1;
        Req = req; WEN = wen; Size = sz; LoadUnsigned = uns; DataAddress = addr; WD = wd;
    endtask

    task automatic rand_inputs();
        case ($urandom_range(0, 3))
            0: DataAddress = $urandom_range(0, 63);
            1: DataAddress = $urandom_range(0, 1023);
            2: DataAddress = $urandom_range(1024, 1100);
            default: DataAddress = $urandom();
        endcase
        Req          = ($urandom_range(0, 3) != 0);
        WEN          = $urandom_range(0, 1);
        Size         = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        LoadUnsigned = $urandom_range(0, 1);
        WD           = $urandom();
    endtask

    // Count edges from a release of rst until Ready, with random traffic meanwhile.
    task automatic count_clear(input int stop_at, output int n);
        n = 0;
        while (n < 400) begin
            @(posedge CLK);
            n++;
            #1;
            if (Ready || n == stop_at) break;
            rand_inputs();
        end
        Req = 1'b0;
    endtask

    initial begin
        int n;
        @(posedge CLK);
        #1;
        cmp_en = 1'b1;
        @(negedge CLK);
        check("reset_rd", RD, 32'h0);
        check("reset_busy", {31'h0, Busy}, 32'h1);
        check("reset_ready", {31'h0, Ready}, 32'h0);

        // Release reset and measure the clear length.
        @(posedge CLK);
        #1;
        rst = 1'b0;
        count_clear(0, n);
        check("clear_edges", n, DEPTH);

        // Sub-word stores merge into one word; testValue untouched.
        drive(1, 1, 2'd2, 0, 32'h10, 32'h1122_3344);
        drive(1, 1, 2'd0, 0, 32'h12, 32'h0000_00AA);
        drive(1, 1, 2'd1, 0, 32'h10, 32'h0000_BEEF);
        drive(1, 0, 2'd2, 0, 32'h10, 32'h0);
        @(negedge CLK);
        check("merge_word", RD, 32'h11AA_BEEF);
        check("merge_model", m_mem[4], 32'h11AA_BEEF);
        check("merge_test_value", {16'h0, testValue}, 32'h0);

        // Load extension.
        drive(1, 1, 2'd2, 0, 32'h0, 32'h0000_80F0);
        drive(1, 0, 2'd0, 0, 32'h0, 32'h0);
        @(negedge CLK);
        check("ld_sbyte", RD, 32'hFFFF_FFF0);
        check("model_sbyte", model_load(2'd0, 1'b0, 32'h0), 32'hFFFF_FFF0);
        drive(1, 0, 2'd0, 1, 32'h0, 32'h0);
        @(negedge CLK);
        check("ld_ubyte", RD, 32'h0000_00F0);
        drive(1, 0, 2'd1, 0, 32'h0, 32'h0);
        @(negedge CLK);
        check("ld_shalf", RD, 32'hFFFF_80F0);
        drive(1, 0, 2'd1, 1, 32'h2, 32'h0);
        @(negedge CLK);
        check("ld_uhalf_hi", RD, 32'h0);
        check("test_value_80f0", {16'h0, testValue}, 32'h80F0);

        // Misaligned stores: first address captured, memory untouched.
        drive(1, 1, 2'd1, 0, 32'h21, 32'h1234);
        @(negedge CLK);
        check("mis_half_err", {31'h0, AccessErr}, 32'h1);
        drive(1, 1, 2'd2, 0, 32'h26, 32'h5678_9ABC);
        @(negedge CLK);
        check("mis_word_err", {31'h0, AccessErr}, 32'h1);
        drive(0, 0, 2'd2, 0, 32'h20, 32'h0);
        @(negedge CLK);
        check("mis_sticky", {31'h0, ErrSticky}, 32'h1);
        check("mis_err_addr", ErrAddr, 32'h21);
        check("mis_word20", RD, 32'h0);
        drive(0, 0, 2'd2, 0, 32'h24, 32'h0);
        @(negedge CLK);
        check("mis_word24", RD, 32'h0);

        // Out of range load and store.
        drive(1, 0, 2'd2, 0, DEPTH * 4, 32'h0);
        @(negedge CLK);
        check("oor_rd", RD, 32'h0);
        check("oor_err", {31'h0, AccessErr}, 32'h1);
        drive(1, 1, 2'd2, 0, DEPTH * 4, 32'hDEAD_BEEF);
        drive(0, 0, 2'd2, 0, DEPTH * 4, 32'h0);
        @(negedge CLK);
        check("oor_idle_rd", RD, 32'h0);
        check("oor_idle_err", {31'h0, AccessErr}, 32'h0);
        check("oor_err_addr_kept", ErrAddr, 32'h21);
        drive(0, 0, 2'd2, 0, 32'h0, 32'h0);
        @(negedge CLK);
        check("oor_word0", RD, 32'h0000_80F0);

        // Read during write: old data before the edge, new data after.
        drive(1, 1, 2'd2, 0, 32'h10, 32'hCAFE_F00D);
        @(negedge CLK);
        check("rdw_old", RD, 32'h11AA_BEEF);
        drive(0, 0, 2'd2, 0, 32'h10, 32'h0);
        @(negedge CLK);
        check("rdw_new", RD, 32'hCAFE_F00D);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK);
            #1;
            rand_inputs();
        end

        // Reset at clear cycle 100 restarts the sequence.
        @(posedge CLK);
        #1;
        Req = 1'b0;
        rst = 1'b1;
        @(posedge CLK);
        #1;
        rst = 1'b0;
        count_clear(100, n);
        check("midclear_reached", n, 100);
        rst = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        rst = 1'b0;
        count_clear(0, n);
        check("restart_clear_edges", n, DEPTH);
        drive(0, 0, 2'd2, 0, 32'h10, 32'h0);
        @(negedge CLK);
        check("restart_cleared", RD, 32'h0);

        for (int i = 0; i < 500; i++) begin
            @(posedge CLK);
            #1;
            rand_inputs();
        end

        @(posedge CLK);
        #1;
        Req = 1'b0;
        @(negedge CLK);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
